// File: rtl/img_capture_ctrl.sv
// ---------------------------------------------------------------------------
// img_capture_ctrl
//   Frame-capture sequencer between the camera pixel stream and the 32-bit
//   image FIFO read by the host. An arm command waits for a frame boundary,
//   writes a start marker, then streams RGB565 pixels (expanded to 8 bits per
//   channel) for a programmed number of frames. Each frame is closed with a
//   trailer word: FE = clean frame, FD = frame truncated by FIFO overflow.
//   The camera is never stalled; overflow drops the rest of the frame.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   cfg_arm             one-cycle pulse, start a capture (ignored while busy)
//   cfg_abort           abandon the capture (wins over cfg_arm)
//   cfg_frames          frames to capture, 0 = continuous, latched on arm
//   img_valid/img_sync  camera pixel strobe / frame-boundary strobe
//   img_data            RGB565 pixel
//   img_ready           backpressure to the camera (1 whenever out of reset)
//   fifo_full           image FIFO full
//   fifo_wr_en/fifo_din registered FIFO write strobe and data
//   busy                capture in progress
//   capture_done        one-cycle pulse with the final trailer write
//   frames_done         frames closed since the last arm (wraps)
//   overflow_count      dropped words/events since the last arm (saturates)
//   last_pixel_count    pixels written in the most recently closed frame
// ---------------------------------------------------------------------------
module img_capture_ctrl #(
  parameter int FRAME_W = 8,
  parameter int COUNT_W = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_arm,
  input  logic               cfg_abort,
  input  logic [FRAME_W-1:0] cfg_frames,
  input  logic               img_valid,
  input  logic               img_sync,
  input  logic [15:0]        img_data,
  output logic               img_ready,
  input  logic               fifo_full,
  output logic               fifo_wr_en,
  output logic [31:0]        fifo_din,
  output logic               busy,
  output logic               capture_done,
  output logic [FRAME_W-1:0] frames_done,
  output logic [7:0]         overflow_count,
  output logic [COUNT_W-1:0] last_pixel_count
);

  localparam logic [31:0] START_MARKER = 32'hFF00_0000;

  typedef enum logic [1:0] {IDLE, WAIT_SYNC, CAPTURE, SKIP} state_t;

  function automatic logic [31:0] px_word(input logic [15:0] p);
    return {8'h00, p[15:11], 3'b000, p[10:5], 2'b00, p[4:0], 3'b000};
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [COUNT_W-1:0] sat_inc_cnt(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + COUNT_W'(1);
  endfunction

  state_t             state, state_n;
  logic [FRAME_W-1:0] frames_lat, frames_lat_n;
  logic [FRAME_W-1:0] frames_done_n, fd_inc;
  logic [7:0]         ovf_n;
  logic [COUNT_W-1:0] pix_cnt, pix_n, last_n;
  logic               wr_vld_p1_n, done_n;
  logic [31:0]        wr_dat_p1_n;

  // The camera is never throttled; ready only drops while held in reset.
  assign img_ready = ~reset;
  assign busy      = (state != IDLE);

  always_comb begin
    state_n       = state;
    frames_lat_n  = frames_lat;
    frames_done_n = frames_done;
    ovf_n         = overflow_count;
    pix_n         = pix_cnt;
    last_n        = last_pixel_count;
    wr_vld_p1_n   = 1'b0;
    wr_dat_p1_n   = fifo_din;
    done_n        = 1'b0;
    fd_inc        = frames_done + FRAME_W'(1);

    if (state != IDLE && cfg_abort) begin
      // Abort leaves every counter untouched so the host can read them back.
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_arm && !cfg_abort) begin
            state_n       = WAIT_SYNC;
            frames_lat_n  = cfg_frames;
            frames_done_n = '0;
            ovf_n         = '0;
            pix_n         = '0;
          end
        end
        WAIT_SYNC: begin
          if (img_sync) begin
            if (!fifo_full) begin
              wr_vld_p1_n = 1'b1;
              wr_dat_p1_n = START_MARKER;
              state_n     = CAPTURE;
            end else begin
              ovf_n = sat_inc8(overflow_count);
            end
          end
        end
        CAPTURE, SKIP: begin
          if (img_sync) begin
            // Frame close; a dropped trailer still closes the frame.
            if (!fifo_full) begin
              wr_vld_p1_n = 1'b1;
              wr_dat_p1_n = {(state == SKIP) ? 8'hFD : 8'hFE, pix_cnt};
            end else begin
              ovf_n = sat_inc8(overflow_count);
            end
            last_n        = pix_cnt;
            pix_n         = '0;
            frames_done_n = fd_inc;
            if (frames_lat != '0 && fd_inc == frames_lat) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end else begin
              state_n = CAPTURE;
            end
          end else if (state == CAPTURE && img_valid) begin
            if (!fifo_full) begin
              wr_vld_p1_n = 1'b1;
              wr_dat_p1_n = px_word(img_data);
              pix_n       = sat_inc_cnt(pix_cnt);
            end else begin
              ovf_n   = sat_inc8(overflow_count);
              state_n = SKIP;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Stage p1: registered FIFO write and status
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      frames_lat       <= '0;
      frames_done      <= '0;
      overflow_count   <= '0;
      pix_cnt          <= '0;
      last_pixel_count <= '0;
      fifo_wr_en       <= 1'b0;
      fifo_din         <= '0;
      capture_done     <= 1'b0;
    end else begin
      state            <= state_n;
      frames_lat       <= frames_lat_n;
      frames_done      <= frames_done_n;
      overflow_count   <= ovf_n;
      pix_cnt          <= pix_n;
      last_pixel_count <= last_n;
      fifo_wr_en       <= wr_vld_p1_n;
      fifo_din         <= wr_dat_p1_n;
      capture_done     <= done_n;
    end
  end

endmodule

// File: tb/tb_img_capture_ctrl.sv
module tb_img_capture_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_arm = 1'b0, cfg_abort = 1'b0;
  logic [7:0]  cfg_frames = 8'd0;
  logic        img_valid = 1'b0, img_sync = 1'b0;
  logic [15:0] img_data = 16'd0;
  logic        img_ready;
  logic        fifo_full = 1'b0;
  logic        fifo_wr_en;
  logic [31:0] fifo_din;
  logic        busy, capture_done;
  logic [7:0]  frames_done, overflow_count;
  logic [23:0] last_pixel_count;

  img_capture_ctrl #(.FRAME_W(8), .COUNT_W(24)) dut (
    .clk(clk), .reset(reset), .cfg_arm(cfg_arm), .cfg_abort(cfg_abort),
    .cfg_frames(cfg_frames), .img_valid(img_valid), .img_sync(img_sync),
    .img_data(img_data), .img_ready(img_ready), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .busy(busy),
    .capture_done(capture_done), .frames_done(frames_done),
    .overflow_count(overflow_count), .last_pixel_count(last_pixel_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: capture session described by a few flags and integers.
  bit m_active, m_started, m_skip;
  int m_lat, m_fd, m_ovf, m_pix, m_last;
  bit e_wr, e_done;
  logic [31:0] e_din;

  function automatic logic [31:0] pixel_of(input logic [15:0] d);
    int r, g, b;
    r = int'(d) >> 11;
    g = (int'(d) >> 5) & 63;
    b = int'(d) & 31;
    return 32'((r << 19) | (g << 10) | (b << 3));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h time=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit arm, input bit abort,
                            input int frames, input bit valid, input bit sync,
                            input logic [15:0] data, input bit full);
    e_wr = 0;
    e_done = 0;
    if (rst) begin
      m_active = 0; m_started = 0; m_skip = 0;
      m_lat = 0; m_fd = 0; m_ovf = 0; m_pix = 0; m_last = 0;
      return;
    end
    if (!m_active) begin
      if (arm && !abort) begin
        m_active = 1; m_started = 0; m_skip = 0;
        m_lat = frames; m_fd = 0; m_ovf = 0; m_pix = 0;
      end
    end else if (abort) begin
      m_active = 0;
    end else if (!m_started) begin
      if (sync) begin
        if (!full) begin e_wr = 1; e_din = 32'hFF000000; m_started = 1; end
        else if (m_ovf < 255) m_ovf++;
      end
    end else if (sync) begin
      if (!full) begin
        e_wr = 1;
        e_din = ((m_skip ? 32'hFD : 32'hFE) << 24) | 32'(m_pix);
      end else if (m_ovf < 255) m_ovf++;
      m_last = m_pix;
      m_pix = 0;
      m_fd = (m_fd + 1) % 256;
      m_skip = 0;
      if (m_lat != 0 && m_fd == m_lat) begin m_active = 0; e_done = 1; end
    end else if (valid && !m_skip) begin
      if (!full) begin
        e_wr = 1;
        e_din = pixel_of(data);
        if (m_pix < 24'hFFFFFF) m_pix++;
      end else begin
        if (m_ovf < 255) m_ovf++;
        m_skip = 1;
      end
    end
  endtask

  // One clock: drive, clock edge, model update, compare half a cycle later.
  task automatic cycle(input bit rst, input bit arm, input bit abort, input int frames,
                       input bit valid, input bit sync, input logic [15:0] data, input bit full);
    reset = rst; cfg_arm = arm; cfg_abort = abort; cfg_frames = 8'(frames);
    img_valid = valid; img_sync = sync; img_data = data; fifo_full = full;
    @(posedge clk);
    model_step(rst, arm, abort, frames, valid, sync, data, full);
    @(negedge clk);
    chk("fifo_wr_en", 32'(fifo_wr_en), 32'(e_wr));
    if (e_wr) chk("fifo_din", fifo_din, e_din);
    chk("capture_done", 32'(capture_done), 32'(e_done));
    chk("busy", 32'(busy), 32'(m_active));
    chk("frames_done", 32'(frames_done), 32'(m_fd));
    chk("overflow_count", 32'(overflow_count), 32'(m_ovf));
    chk("last_pixel_count", 32'(last_pixel_count), 32'(m_last));
    chk("img_ready", 32'(img_ready), rst ? 32'd0 : 32'd1);
  endtask

  task automatic idle();                   cycle(0,0,0,0,0,0,16'h0,0); endtask
  task automatic arm_f(input int f);       cycle(0,1,0,f,0,0,16'h0,0); endtask
  task automatic px(input logic [15:0] d, input bit full); cycle(0,0,0,0,1,0,d,full); endtask
  task automatic sy(input bit full);       cycle(0,0,0,0,0,1,16'h0,full); endtask
  task automatic do_reset();               cycle(1,0,0,0,0,0,16'h0,0); cycle(1,0,0,0,0,0,16'h0,0); endtask

  typedef struct {
    logic        arm;
    logic [7:0]  frames;
    logic        valid;
    logic        sync;
    logic [15:0] data;
    logic        exp_wr;
    logic [31:0] exp_din;
    logic        exp_done;
    logic        exp_busy;
  } vec_t;

  vec_t tbl[8];

  task automatic run_table(input string tag);
    for (int i = 0; i < 8; i++) begin
      cycle(0, tbl[i].arm, 0, int'(tbl[i].frames), tbl[i].valid, tbl[i].sync, tbl[i].data, 0);
      chk({tag, "_wr"}, 32'(fifo_wr_en), 32'(tbl[i].exp_wr));
      if (tbl[i].exp_wr) chk({tag, "_din"}, fifo_din, tbl[i].exp_din);
      chk({tag, "_done"}, 32'(capture_done), 32'(tbl[i].exp_done));
      chk({tag, "_busy"}, 32'(busy), 32'(tbl[i].exp_busy));
    end
    chk({tag, "_frames_done"}, 32'(frames_done), 32'd1);
    chk({tag, "_last_count"}, 32'(last_pixel_count), 32'd4);
  endtask

  initial begin
    //          arm frames valid sync data     wr din            done busy
    tbl[0] = '{1'b1, 8'd1, 1'b0, 1'b0, 16'h0000, 1'b0, 32'h00000000, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 8'd0, 1'b0, 1'b1, 16'h0000, 1'b1, 32'hFF000000, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 8'd0, 1'b1, 1'b0, 16'hFFFF, 1'b1, 32'h00F8FCF8, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 8'd0, 1'b1, 1'b0, 16'hFFFF, 1'b1, 32'h00F8FCF8, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 8'd0, 1'b1, 1'b0, 16'hFFFF, 1'b1, 32'h00F8FCF8, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 8'd0, 1'b1, 1'b0, 16'hFFFF, 1'b1, 32'h00F8FCF8, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 8'd0, 1'b0, 1'b1, 16'h0000, 1'b1, 32'hFE000004, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 8'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 32'h00000000, 1'b0, 1'b0};

    @(negedge clk);
    do_reset();
    chk("reset_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ready", 32'(img_ready), 32'd0);
    idle();
    chk("ready_after_reset", 32'(img_ready), 32'd1);

    // Single frame of four white pixels.
    run_table("single");

    // Continuous capture, frames of 2, 3 and 0 pixels, then abort.
    arm_f(0); sy(0);
    px(16'h1234, 0); px(16'hF800, 0);
    sy(0); chk("cont_trailer2", fifo_din, 32'hFE000002);
    px(16'h07E0, 0); px(16'h001F, 0); px(16'hABCD, 0);
    sy(0); chk("cont_trailer3", fifo_din, 32'hFE000003);
    sy(0); chk("cont_trailer0", fifo_din, 32'hFE000000);
    chk("cont_busy", 32'(busy), 32'd1);
    cycle(0,0,1,0,0,1,16'h0,0);
    chk("abort_no_write", 32'(fifo_wr_en), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);
    chk("abort_frames_held", 32'(frames_done), 32'd3);
    idle();

    // Overflow mid-frame: FD trailer, then a clean second frame.
    arm_f(2); sy(0);
    px(16'h1111, 0); px(16'h2222, 0);
    px(16'h3333, 1);
    chk("ovf_drop_wr", 32'(fifo_wr_en), 32'd0);
    px(16'h4444, 0);
    chk("skip_no_wr", 32'(fifo_wr_en), 32'd0);
    sy(0); chk("bad_trailer", fifo_din, 32'hFD000002);
    chk("ovf_count1", 32'(overflow_count), 32'd1);
    px(16'h5555, 0); sy(0);
    chk("ovf_good_trailer", fifo_din, 32'hFE000001);
    chk("ovf_capture_done", 32'(capture_done), 32'd1);
    idle();

    // FIFO full at the first sync: no marker, counted; next sync starts.
    arm_f(1); sy(1);
    chk("wait_full_no_wr", 32'(fifo_wr_en), 32'd0);
    chk("wait_full_ovf", 32'(overflow_count), 32'd1);
    sy(0); chk("late_marker", fifo_din, 32'hFF000000);
    px(16'h0001, 0); sy(0);
    chk("late_trailer", fifo_din, 32'hFE000001);
    idle();

    // Sync and pixel together; arm while busy must not relatch frames.
    arm_f(2); sy(0); px(16'hAAAA, 0);
    cycle(0,0,0,0,1,1,16'hBBBB,0);
    chk("sync_wins_din", fifo_din, 32'hFE000001);
    arm_f(5);
    px(16'hCCCC, 0); sy(0);
    chk("busy_arm_ignored_done", 32'(capture_done), 32'd1);
    chk("busy_arm_frames", 32'(frames_done), 32'd2);
    idle();

    // Reset mid-frame after ten pixels, then a fresh single-frame capture.
    arm_f(0); sy(0);
    for (int i = 0; i < 10; i++) px(16'(i * 997), 0);
    cycle(1,0,0,0,1,1,16'h0,0);
    chk("midreset_wr", 32'(fifo_wr_en), 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_fd", 32'(frames_done), 32'd0);
    chk("midreset_last", 32'(last_pixel_count), 32'd0);
    idle();
    run_table("rearm");

    // Randomised traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom % 600) == 0, ($urandom % 15) == 0, ($urandom % 120) == 0,
            int'($urandom % 4), ($urandom % 3) != 0, ($urandom % 10) == 0,
            16'($urandom), ($urandom % 7) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
